mips_cpu: RTL and testbench

- Single-cycle MIPS-I subset processor with internal instruction ROM, data RAM and 32x32 register file.
- Executes one instruction per rising clock edge while running_switch is high.
- Exposes register $t0 (r8) as a debug/LED output.
- Top-level compute block of the FPGA design; the board switch gates execution.

---
 rtl/mips_pkg.sv | 64 ++++++
 rtl/mips_regfile.sv | 34 +++
 rtl/mips_cpu.sv | 167 ++++++++++++++++
 tb/tb_mips_cpu.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the single-cycle MIPS core: opcodes, functs, ALU ops,
// architectural register indices and the built-in boot program.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_JR   = 6'h08;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
        ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
    } alu_op_e;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_T0   = 5'd8;
    localparam logic [4:0] REG_T1   = 5'd9;
    localparam logic [4:0] REG_T2   = 5'd10;
    localparam logic [4:0] REG_RA   = 5'd31;

    // 12*12 by repeated addition through a jal/jr subroutine, then sw/lw round trip.
    function automatic logic [31:0] default_program(input int unsigned idx);
        case (idx)
            0:       return 32'h2009000C; // addi t1, zero, 12
            1:       return 32'h20080000; // addi t0, zero, 0
            2:       return 32'h0C000009; // loop: jal add12
            3:       return 32'h2129FFFF; // addi t1, t1, -1
            4:       return 32'h1520FFFD; // bne  t1, zero, loop
            5:       return 32'hAC080000; // sw   t0, 0(zero)
            6:       return 32'h20080000; // addi t0, zero, 0
            7:       return 32'h8C080000; // lw   t0, 0(zero)
            8:       return 32'h08000008; // done: j done
            9:       return 32'h2108000C; // add12: addi t0, t0, 12
            10:      return 32'h03E00008; // jr   ra
            default: return 32'h00000000;
        endcase
    endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port,
// r0 hard-wired to zero, whole array cleared while running_switch is low.
module mips_regfile
    import mips_pkg::*;
(
    input  logic        clock,
    input  logic        running_switch,
    input  logic [4:0]  ra1_i,
    input  logic [4:0]  ra2_i,
    output logic [31:0] rd1_o,
    output logic [31:0] rd2_o,
    input  logic        we_i,
    input  logic [4:0]  wa_i,
    input  logic [31:0] wd_i,
    output logic [31:0] t0_o
);

    logic [31:0] register_file [0:31];

    always_ff @(posedge clock) begin
        if (!running_switch) begin
            for (int i = 0; i < 32; i++) begin
                register_file[i] <= '0;
            end
        end else if (we_i && (wa_i != REG_ZERO)) begin
            register_file[wa_i] <= wd_i;
        end
    end

    assign rd1_o = (ra1_i == REG_ZERO) ? '0 : register_file[ra1_i];
    assign rd2_o = (ra2_i == REG_ZERO) ? '0 : register_file[ra2_i];
    assign t0_o  = register_file[REG_T0];

endmodule

// File: rtl/mips_cpu.sv
// Single-cycle MIPS-I subset core: one instruction committed per rising edge
// while running_switch is high; $t0 is exported for the board LEDs.
module mips_cpu
    import mips_pkg::*;
#(
    parameter int    IMEM_DEPTH = 256,
    parameter int    DMEM_DEPTH = 256,
    parameter string IMEM_INIT  = "program.hex"
) (
    input  logic        clock,
    input  logic        running_switch,
    output logic [31:0] reg_t0
);

    localparam int IA_W = $clog2(IMEM_DEPTH);
    localparam int DA_W = $clog2(DMEM_DEPTH);

    logic [31:0] imem [IMEM_DEPTH];
    logic [31:0] dmem [DMEM_DEPTH];

    initial begin
        for (int i = 0; i < IMEM_DEPTH; i++) begin
            imem[i] = default_program(i);
        end
    end

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr, pc_plus4;
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;

    assign instr    = imem[pc_q[IA_W+1:2]];
    assign op       = instr[31:26];
    assign rs       = instr[25:21];
    assign rt       = instr[20:16];
    assign rd       = instr[15:11];
    assign shamt    = instr[10:6];
    assign funct    = instr[5:0];
    assign imm      = instr[15:0];
    assign pc_plus4 = pc_q + 32'd4;

    alu_op_e     alu_op;
    logic        use_imm, imm_zext, reg_we, dst_rd, mem_to_reg, mem_we;
    logic        is_beq, is_bne, is_j, is_jal, is_jr;

    always_comb begin
        alu_op     = ALU_ADD;
        use_imm    = 1'b0;
        imm_zext   = 1'b0;
        reg_we     = 1'b0;
        dst_rd     = 1'b0;
        mem_to_reg = 1'b0;
        mem_we     = 1'b0;
        is_beq     = 1'b0;
        is_bne     = 1'b0;
        is_j       = 1'b0;
        is_jal     = 1'b0;
        is_jr      = 1'b0;
        case (op)
            OP_RTYPE: begin
                dst_rd = 1'b1;
                reg_we = 1'b1;
                case (funct)
                    F_ADD, F_ADDU: alu_op = ALU_ADD;
                    F_SUB, F_SUBU: alu_op = ALU_SUB;
                    F_AND:         alu_op = ALU_AND;
                    F_OR:          alu_op = ALU_OR;
                    F_XOR:         alu_op = ALU_XOR;
                    F_NOR:         alu_op = ALU_NOR;
                    F_SLT:         alu_op = ALU_SLT;
                    F_SLTU:        alu_op = ALU_SLTU;
                    F_SLL:         alu_op = ALU_SLL;
                    F_SRL:         alu_op = ALU_SRL;
                    F_SRA:         alu_op = ALU_SRA;
                    F_JR: begin
                        reg_we = 1'b0;
                        is_jr  = 1'b1;
                    end
                    default:       reg_we = 1'b0;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin use_imm = 1'b1; reg_we = 1'b1; end
            OP_SLTI: begin alu_op = ALU_SLT; use_imm = 1'b1; reg_we = 1'b1; end
            OP_ANDI: begin alu_op = ALU_AND; use_imm = 1'b1; imm_zext = 1'b1; reg_we = 1'b1; end
            OP_ORI:  begin alu_op = ALU_OR;  use_imm = 1'b1; imm_zext = 1'b1; reg_we = 1'b1; end
            OP_XORI: begin alu_op = ALU_XOR; use_imm = 1'b1; imm_zext = 1'b1; reg_we = 1'b1; end
            OP_LUI:  begin alu_op = ALU_LUI; use_imm = 1'b1; imm_zext = 1'b1; reg_we = 1'b1; end
            OP_LW:   begin use_imm = 1'b1; reg_we = 1'b1; mem_to_reg = 1'b1; end
            OP_SW:   begin use_imm = 1'b1; mem_we = 1'b1; end
            OP_BEQ:  is_beq = 1'b1;
            OP_BNE:  is_bne = 1'b1;
            OP_J:    is_j = 1'b1;
            OP_JAL:  begin is_jal = 1'b1; reg_we = 1'b1; end
            default: ;
        endcase
    end

    logic [31:0] rs_val, rt_val, imm_ext, alu_b, alu_res, mem_rdata, wb_data;
    logic [4:0]  wb_addr;

    assign imm_ext = imm_zext ? {16'h0, imm} : {{16{imm[15]}}, imm};
    assign alu_b   = use_imm ? imm_ext : rt_val;

    // Shifts take their operand from rt (via alu_b) and the amount from shamt.
    always_comb begin
        alu_res = '0;
        case (alu_op)
            ALU_ADD:  alu_res = rs_val + alu_b;
            ALU_SUB:  alu_res = rs_val - alu_b;
            ALU_AND:  alu_res = rs_val & alu_b;
            ALU_OR:   alu_res = rs_val | alu_b;
            ALU_XOR:  alu_res = rs_val ^ alu_b;
            ALU_NOR:  alu_res = ~(rs_val | alu_b);
            ALU_SLT:  alu_res = {31'h0, $signed(rs_val) < $signed(alu_b)};
            ALU_SLTU: alu_res = {31'h0, rs_val < alu_b};
            ALU_SLL:  alu_res = alu_b << shamt;
            ALU_SRL:  alu_res = alu_b >> shamt;
            ALU_SRA:  alu_res = $unsigned($signed(alu_b) >>> shamt);
            ALU_LUI:  alu_res = {alu_b[15:0], 16'h0};
            default:  alu_res = '0;
        endcase
    end

    assign mem_rdata = dmem[alu_res[DA_W+1:2]];
    assign wb_addr   = is_jal ? REG_RA : (dst_rd ? rd : rt);
    assign wb_data   = is_jal ? pc_plus4 : (mem_to_reg ? mem_rdata : alu_res);

    mips_regfile regfile (
        .clock          (clock),
        .running_switch (running_switch),
        .ra1_i          (rs),
        .ra2_i          (rt),
        .rd1_o          (rs_val),
        .rd2_o          (rt_val),
        .we_i           (reg_we),
        .wa_i           (wb_addr),
        .wd_i           (wb_data),
        .t0_o           (reg_t0)
    );

    always_ff @(posedge clock) begin
        if (running_switch && mem_we) begin
            dmem[alu_res[DA_W+1:2]] <= rt_val;
        end
    end

    always_comb begin
        pc_d = pc_plus4;
        if ((is_beq && (rs_val == rt_val)) || (is_bne && (rs_val != rt_val))) begin
            pc_d = pc_plus4 + {{14{imm[15]}}, imm, 2'b00};
        end else if (is_j || is_jal) begin
            pc_d = {pc_plus4[31:28], instr[25:0], 2'b00};
        end else if (is_jr) begin
            pc_d = rs_val;
        end
    end

    always_ff @(posedge clock) begin
        if (!running_switch) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: tb/tb_mips_cpu.sv
// Directed bench for mips_cpu: reset hold, built-in 12*12 program, reset mid-run,
// and hand-encoded programs for ALU/immediates, memory/branch, compares/shifts and call/return.
module tb_mips_cpu;

    logic        clock = 1'b0;
    logic        running_switch = 1'b0;
    logic [31:0] reg_t0;

    int n_cmp = 0;
    int n_bad = 0;

    mips_cpu #(
        .IMEM_DEPTH (256),
        .DMEM_DEPTH (256),
        .IMEM_INIT  ("")
    ) dut (
        .clock          (clock),
        .running_switch (running_switch),
        .reg_t0         (reg_t0)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] j_ins(input logic [5:0] op, input logic [25:0] widx);
        return {op, widx};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) dut.imem[i] = 32'h0;
    endtask

    function automatic logic [31:0] rf(input int idx);
        return dut.regfile.register_file[idx];
    endfunction

    initial begin
        // Reset hold
        running_switch = 1'b0;
        cycles(100);
        chk("hold_pc", dut.pc_q, 32'h0);
        chk("hold_t0", reg_t0, 32'h0);
        for (int i = 0; i < 32; i++) chk($sformatf("hold_r%0d", i), rf(i), 32'h0);

        // Built-in program
        running_switch = 1'b1;
        cycles(1000);
        chk("dflt_rf8", rf(8), 32'd144);
        chk("dflt_t0", reg_t0, 32'd144);
        chk("dflt_pc", dut.pc_q, 32'h20);
        chk("dflt_mem0", dut.dmem[0], 32'd144);

        // Reset mid-run
        running_switch = 1'b0;
        cycles(1);
        running_switch = 1'b1;
        cycles(20);
        running_switch = 1'b0;
        cycles(1);
        chk("mid_t0_a", reg_t0, 32'h0);
        chk("mid_pc_a", dut.pc_q, 32'h0);
        cycles(1);
        chk("mid_t0_b", reg_t0, 32'h0);
        running_switch = 1'b1;
        cycles(1000);
        chk("mid_t0_end", reg_t0, 32'd144);
        chk("mid_pc_end", dut.pc_q, 32'h20);

        // ALU / immediates
        running_switch = 1'b0;
        cycles(2);
        clear_rom();
        dut.imem[0] = i_ins(6'h08, 5'd0, 5'd8, 16'd5);
        dut.imem[1] = i_ins(6'h08, 5'd0, 5'd9, 16'd7);
        dut.imem[2] = r_ins(5'd8, 5'd9, 5'd8, 5'd0, 6'h20);
        dut.imem[3] = r_ins(5'd8, 5'd9, 5'd10, 5'd0, 6'h22);
        dut.imem[4] = i_ins(6'h0F, 5'd0, 5'd9, 16'h1234);
        dut.imem[5] = i_ins(6'h0D, 5'd9, 5'd9, 16'h5678);
        dut.imem[6] = i_ins(6'h08, 5'd0, 5'd0, 16'd1);
        dut.imem[7] = j_ins(6'h02, 26'd7);
        chk("alu_rst_t0", reg_t0, 32'h0);
        running_switch = 1'b1;
        cycles(6);
        chk("alu_t0", rf(8), 32'd12);
        chk("alu_t2", rf(10), 32'd5);
        chk("alu_t1", rf(9), 32'h12345678);
        chk("alu_pc", dut.pc_q, 32'h18);
        cycles(1);
        chk("alu_r0", rf(0), 32'h0);
        cycles(3);
        chk("alu_selfjump", dut.pc_q, 32'h1C);

        // Memory / branch / compares / shifts
        running_switch = 1'b0;
        cycles(2);
        clear_rom();
        dut.imem[0]  = i_ins(6'h08, 5'd0, 5'd8, 16'd42);
        dut.imem[1]  = i_ins(6'h2B, 5'd0, 5'd8, 16'd4);
        dut.imem[2]  = i_ins(6'h23, 5'd0, 5'd10, 16'd4);
        dut.imem[3]  = i_ins(6'h04, 5'd8, 5'd10, 16'd1);
        dut.imem[4]  = i_ins(6'h08, 5'd0, 5'd8, 16'd99);
        dut.imem[5]  = i_ins(6'h08, 5'd0, 5'd9, 16'hFFFF);
        dut.imem[6]  = i_ins(6'h08, 5'd0, 5'd13, 16'd1);
        dut.imem[7]  = r_ins(5'd9, 5'd13, 5'd11, 5'd0, 6'h2A);
        dut.imem[8]  = r_ins(5'd9, 5'd13, 5'd12, 5'd0, 6'h2B);
        dut.imem[9]  = r_ins(5'd0, 5'd9, 5'd14, 5'd4, 6'h03);
        dut.imem[10] = r_ins(5'd0, 5'd9, 5'd15, 5'd28, 6'h02);
        dut.imem[11] = r_ins(5'd0, 5'd13, 5'd16, 5'd31, 6'h00);
        dut.imem[12] = r_ins(5'd0, 5'd0, 5'd17, 5'd0, 6'h27);
        dut.imem[13] = r_ins(5'd8, 5'd13, 5'd18, 5'd0, 6'h26);
        dut.imem[14] = j_ins(6'h02, 26'd14);
        running_switch = 1'b1;
        cycles(4);
        chk("br_taken_pc", dut.pc_q, 32'h14);
        chk("mem_lw_t2", rf(10), 32'd42);
        cycles(12);
        chk("br_skip_t0", rf(8), 32'd42);
        chk("mem_word1", dut.dmem[1], 32'd42);
        chk("slt_neg", rf(11), 32'd1);
        chk("sltu_neg", rf(12), 32'd0);
        chk("sra", rf(14), 32'hFFFFFFFF);
        chk("srl", rf(15), 32'h0000000F);
        chk("sll", rf(16), 32'h80000000);
        chk("nor", rf(17), 32'hFFFFFFFF);
        chk("xor", rf(18), 32'd43);
        chk("br_selfjump", dut.pc_q, 32'h38);

        // Call / return, with an unrecognised opcode as a NOP
        running_switch = 1'b0;
        cycles(2);
        clear_rom();
        dut.imem[0] = i_ins(6'h08, 5'd0, 5'd8, 16'd1);
        dut.imem[1] = i_ins(6'h3F, 5'd0, 5'd8, 16'h00FF);
        dut.imem[4] = j_ins(6'h03, 26'd8);
        dut.imem[5] = i_ins(6'h08, 5'd8, 5'd8, 16'd100);
        dut.imem[6] = j_ins(6'h02, 26'd6);
        dut.imem[8] = i_ins(6'h08, 5'd0, 5'd9, 16'd3);
        dut.imem[9] = r_ins(5'd31, 5'd0, 5'd0, 5'd0, 6'h08);
        running_switch = 1'b1;
        cycles(2);
        chk("badop_t0", rf(8), 32'd1);
        chk("badop_pc", dut.pc_q, 32'h8);
        cycles(3);
        chk("jal_pc", dut.pc_q, 32'h20);
        chk("jal_ra", rf(31), 32'h14);
        cycles(1);
        chk("sub_t1", rf(9), 32'd3);
        cycles(1);
        chk("jr_pc", dut.pc_q, 32'h14);
        cycles(1);
        chk("ret_t0", reg_t0, 32'd101);
        cycles(2);
        chk("ret_selfjump", dut.pc_q, 32'h18);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
